ka_seq_mult: RTL and testbench

Parametrised, sequential Karatsuba carry-less multiplier over GF(2)[x]. Applies one Karatsuba split to W-bit operands. The three half-width sub-products go through a single shared combinational multiplier, one per cycle. Adds valid/ready handshaking and optional per-transaction reduction modulo a fixed field polynomial. It is the area-lean successor to the fixed-width combinational Karatsuba trees and serves as the field multiplier for the GF(2^163) datapath.

---
 rtl/ka_pkg.sv | 20 ++
 rtl/ka_seq_mult_if.sv | 8 +
 rtl/clmul_comb.sv | 11 +
 rtl/ka_seq_mult.sv | 81 ++++++++
 tb/tb_ka_seq_mult.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/ka_pkg.sv
// ka_pkg: shared FSM states, field constants and the GF(2) polynomial reduction helper.
package ka_pkg;
  typedef enum logic [2:0] {IDLE, LO, HI, MID, RED, DONE} state_e;
  localparam int W163 = 163;
  localparam logic [162:0] POLY163 = 163'hC9;
  localparam int W21 = 21;
  localparam logic [20:0] POLY21 = 21'h5;
  localparam int MAXW = W163;
  // Folds bits 2w-2..w down from the top; clearing bit i accounts for the implicit x^w term.
  function automatic logic [MAXW-1:0] gf2_reduce(input logic [2*MAXW-2:0] p, input logic [MAXW-1:0] poly, input int w);
    logic [2*MAXW-2:0] r;
    r = p;
    for (int i = 2*MAXW-2; i > 0; i--)
      if (i >= w && i <= 2*w-2 && r[i]) begin
        r[i] = 1'b0;
        r = r ^ ((2*MAXW-1)'(poly) << (i - w));
      end
    return r[MAXW-1:0];
  endfunction
endpackage

// File: rtl/ka_seq_mult_if.sv
// ka_seq_mult_if: operand and result handshake bundle of the sequential Karatsuba multiplier.
interface ka_seq_mult_if #(parameter int W = 163);
  logic in_valid, in_ready, reduce, out_valid, out_ready;
  logic [W-1:0] a, b;
  logic [2*W-2:0] out_y;
  modport master(output in_valid, a, b, reduce, out_ready, input in_ready, out_valid, out_y);
  modport slave(input in_valid, a, b, reduce, out_ready, output in_ready, out_valid, out_y);
endinterface

// File: rtl/clmul_comb.sv
// clmul_comb: combinational NxN schoolbook carry-less multiplier.
module clmul_comb #(parameter int N = 8) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-2:0] p_o
);
  always_comb begin
    p_o = '0;
    for (int i = 0; i < N; i++) p_o = b_i[i] ? p_o ^ ((2*N-1)'(a_i) << i) : p_o;
  end
endmodule

// File: rtl/ka_seq_mult.sv
// ka_seq_mult: one-level Karatsuba carry-less multiplier sharing a single half-width multiplier over three cycles.
module ka_seq_mult import ka_pkg::*; #(
  parameter int W = W163,
  parameter logic [W-1:0] POLY = W'(POLY163)
) (
  input logic clk,
  input logic rst,
  ka_seq_mult_if.slave io
);
  localparam int H = (W + 1) / 2;
  state_e state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic red_q, red_d;
  logic [2*H-2:0] p_lo_q, p_lo_d, p_hi_q, p_hi_d, p;
  logic [2*W-2:0] y_q, y_d;
  logic [H-1:0] a_hi, b_hi, a_mid, b_mid, op_a, op_b;
  assign a_hi = H'(a_q[W-1:H]);
  assign b_hi = H'(b_q[W-1:H]);
  assign a_mid = a_q[H-1:0] ^ a_hi;
  assign b_mid = b_q[H-1:0] ^ b_hi;
  assign op_a = state_q == LO ? a_q[H-1:0] : state_q == HI ? a_hi : a_mid;
  assign op_b = state_q == LO ? b_q[H-1:0] : state_q == HI ? b_hi : b_mid;
  clmul_comb #(.N(H)) u_mul (.a_i(op_a), .b_i(op_b), .p_o(p));
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    red_d = red_q;
    p_lo_d = p_lo_q;
    p_hi_d = p_hi_q;
    y_d = y_q;
    unique case (state_q)
      IDLE: if (io.in_valid) begin
        a_d = io.a;
        b_d = io.b;
        red_d = io.reduce;
        state_d = LO;
      end
      LO: begin
        p_lo_d = p;
        state_d = HI;
      end
      HI: begin
        p_hi_d = p;
        state_d = MID;
      end
      MID: begin
        y_d = (2*W-1)'((4*H-1)'(p_lo_q) ^ ((4*H-1)'(p_lo_q ^ p_hi_q ^ p) << H) ^ ((4*H-1)'(p_hi_q) << (2*H)));
        state_d = red_q ? RED : DONE;
      end
      RED: begin
        y_d = (2*W-1)'(gf2_reduce((2*MAXW-1)'(y_q), MAXW'(POLY), W));
        state_d = DONE;
      end
      DONE: state_d = io.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      red_q <= 1'b0;
      p_lo_q <= '0;
      p_hi_q <= '0;
      y_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      red_q <= red_d;
      p_lo_q <= p_lo_d;
      p_hi_q <= p_hi_d;
      y_q <= y_d;
    end
  end
  assign io.in_ready = state_q == IDLE && !rst;
  assign io.out_valid = state_q == DONE;
  assign io.out_y = y_q;
endmodule

// File: tb/tb_ka_seq_mult.sv
// tb_ka_seq_mult: directed 21-bit vectors plus a randomised 163-bit run against a reference carry-less multiply.
module tb_ka_seq_mult;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ka_seq_mult_if #(.W(21)) s();
  ka_seq_mult_if #(.W(163)) l();
  ka_seq_mult #(.W(21), .POLY(21'h5)) u_s (.clk(clk), .rst(rst), .io(s.slave));
  ka_seq_mult u_l (.clk(clk), .rst(rst), .io(l.slave));
  int n_cmp = 0;
  int n_err = 0;
  task automatic check(input string tag, input logic [325:0] got, input logic [325:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [325:0] ref_mul(input logic [162:0] a, input logic [162:0] b);
    logic [325:0] p;
    p = '0;
    for (int i = 0; i < 163; i++) if (b[i]) p = p ^ (326'(a) << i);
    return p;
  endfunction
  function automatic logic [325:0] ref_mod(input logic [325:0] p, input logic [162:0] poly, input int w);
    logic [325:0] f, r;
    f = (326'(1) << w) | 326'(poly);
    r = p;
    for (int i = 325; i >= w; i--) if (r[i]) r = r ^ (f << (i - w));
    return r;
  endfunction
  function automatic logic [162:0] rnd163();
    return 163'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction
  task automatic run_s(input string tag, input logic [20:0] a, input logic [20:0] b, input logic red,
                       input logic [40:0] exp, input int lat);
    int cnt;
    cnt = 0;
    check({tag, "_in_ready"}, 326'(s.in_ready), 326'(1));
    s.a = a;
    s.b = b;
    s.reduce = red;
    s.in_valid = 1'b1;
    tick();
    s.in_valid = 1'b0;
    s.a = ~a;
    s.b = 21'($urandom);
    s.reduce = ~red;
    while (!s.out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check({tag, "_latency"}, 326'(cnt), 326'(lat));
    check({tag, "_y"}, 326'(s.out_y), 326'(exp));
    s.out_ready = 1'b1;
    tick();
    s.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 326'(s.out_valid), 326'(0));
    check({tag, "_ready_back"}, 326'(s.in_ready), 326'(1));
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int cnt;
    int stall;
    logic [162:0] ra, rb;
    logic rr;
    logic [325:0] exp;
    {s.in_valid, s.reduce, s.out_ready, l.in_valid, l.reduce, l.out_ready} = '0;
    s.a = '0;
    s.b = '0;
    l.a = '0;
    l.b = '0;
    repeat (2) tick();
    check("rst_in_ready", 326'(s.in_ready), 326'(0));
    check("rst_out_valid", 326'(s.out_valid), 326'(0));
    check("rst_out_y", 326'(s.out_y), 326'(0));
    check("rst_l_out_valid", 326'(l.out_valid), 326'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 326'(s.in_ready), 326'(1));
    run_s("x1_sq", 21'h3, 21'h3, 1'b0, 41'h5, 3);
    run_s("ones_sq", 21'h1FFFFF, 21'h1FFFFF, 1'b0, 41'h155_5555_5555, 3);
    run_s("top_red", 21'h100000, 21'h100000, 1'b1, 41'h80005, 4);
    run_s("top_full", 21'h100000, 21'h100000, 1'b0, 41'h100_0000_0000, 3);
    s.a = 21'h3;
    s.b = 21'h3;
    s.reduce = 1'b0;
    s.in_valid = 1'b1;
    tick();
    cnt = 0;
    while (!s.out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check("bp_latency", 326'(cnt), 326'(3));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold", 326'({s.out_valid, s.in_ready, s.out_y}), 326'({1'b1, 1'b0, 41'h5}));
    end
    s.in_valid = 1'b0;
    s.out_ready = 1'b1;
    tick();
    s.out_ready = 1'b0;
    check("bp_valid_drop", 326'(s.out_valid), 326'(0));
    check("bp_ready_back", 326'(s.in_ready), 326'(1));
    s.a = 21'h1FFFFF;
    s.b = 21'h1FFFFF;
    s.in_valid = 1'b1;
    tick();
    s.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("hi_rst_valid", 326'(s.out_valid), 326'(0));
    check("hi_rst_y", 326'(s.out_y), 326'(0));
    check("hi_rst_in_ready", 326'(s.in_ready), 326'(0));
    rst = 1'b0;
    #1;
    check("hi_rst_ready_back", 326'(s.in_ready), 326'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hi_rst_no_pulse", 326'({s.out_valid, s.out_y}), 326'(0));
    end
    run_s("fresh_one", 21'h1, 21'h1, 1'b0, 41'h1, 3);
    for (int t = 0; t < 2000; t++) begin
      ra = rnd163();
      rb = rnd163();
      rr = 1'($urandom);
      exp = rr ? ref_mod(ref_mul(ra, rb), 163'hC9, 163) : ref_mul(ra, rb);
      l.a = ra;
      l.b = rb;
      l.reduce = rr;
      l.in_valid = 1'b1;
      tick();
      l.in_valid = 1'b0;
      l.a = rnd163();
      cnt = 0;
      while (!l.out_valid && cnt < 20) begin
        tick();
        cnt++;
      end
      check("rnd_latency", 326'(cnt), rr ? 326'(4) : 326'(3));
      check("rnd_y", 326'(l.out_y), exp);
      stall = int'($urandom_range(0, 3));
      repeat (stall) tick();
      check("rnd_stall_hold", 326'({l.out_valid, l.in_ready, l.out_y}), {1'b1, 1'b0, exp[324:0]});
      l.out_ready = 1'b1;
      tick();
      l.out_ready = 1'b0;
      check("rnd_single_result", 326'({l.out_valid, l.in_ready}), 326'(1));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
